// File: rtl/sonic_pcs_pg_pkg.sv
// Shared types and polynomial constants for the PCS pattern-generator PRBS source.
package sonic_pcs_pg_pkg;

  typedef enum logic [1:0] {
    PAT_PRBS7   = 2'd0,
    PAT_PRBS15  = 2'd1,
    PAT_PRBS31  = 2'd2,
    PAT_CLK1010 = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN
  } state_e;

  localparam int unsigned LFSR_W = 31;

  // Polynomial x^ORDER + x^TAP + 1; both terms are tapped in Fibonacci form
  localparam int unsigned PRBS7_ORDER  = 7;
  localparam int unsigned PRBS7_TAP    = 6;
  localparam int unsigned PRBS15_ORDER = 15;
  localparam int unsigned PRBS15_TAP   = 14;
  localparam int unsigned PRBS31_ORDER = 31;
  localparam int unsigned PRBS31_TAP   = 28;

  function automatic logic [LFSR_W-1:0] order_mask(input pattern_e p);
    logic [31:0] m;
    case (p)
      PAT_PRBS7:  m = (32'd1 << PRBS7_ORDER)  - 32'd1;
      PAT_PRBS15: m = (32'd1 << PRBS15_ORDER) - 32'd1;
      PAT_PRBS31: m = (32'd1 << PRBS31_ORDER) - 32'd1;
      default:    m = '1;
    endcase
    return m[LFSR_W-1:0];
  endfunction

  function automatic logic feedback(input logic [LFSR_W-1:0] s, input pattern_e p);
    case (p)
      PAT_PRBS7:  return s[PRBS7_ORDER-1]  ^ s[PRBS7_TAP-1];
      PAT_PRBS15: return s[PRBS15_ORDER-1] ^ s[PRBS15_TAP-1];
      PAT_PRBS31: return s[PRBS31_ORDER-1] ^ s[PRBS31_TAP-1];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sonic_pcs_pg_if.sv
// Pattern-select input stream and generated-word output stream of the PRBS generator.
interface sonic_pcs_pg_if #(
  parameter int unsigned DATA_WIDTH = 40
);
  logic [1:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/sonic_pcs_pg_lfsr_step.sv
// Combinational DATA_WIDTH-step parallel LFSR; bits[0] is the first bit generated.
module sonic_pcs_pg_lfsr_step
  import sonic_pcs_pg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 40
) (
  input  logic [LFSR_W-1:0]     state,
  input  pattern_e              pattern,
  output logic [LFSR_W-1:0]     next_state,
  output logic [DATA_WIDTH-1:0] bits
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  always_comb begin
    s          = state;
    fb         = 1'b0;
    bits       = '0;
    next_state = state;
    if (pattern == PAT_CLK1010) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        bits[i] = i[0];
      end
    end else begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        fb      = feedback(s, pattern);
        bits[i] = fb;
        s       = {s[LFSR_W-2:0], fb};
      end
      // Bits above the polynomial order carry shifted-out history; drop them
      next_state = s & order_mask(pattern);
    end
  end

endmodule

// File: rtl/sonic_pcs_pg_prbs_generator.sv
// PRBS7/15/31 and 1010 clock-pattern word source with delivered-word counter.
// Optional bit-0 error injection is built when SONIC_PCS_PG_ERR_INJECT_EN is defined.
module sonic_pcs_pg_prbs_generator
  import sonic_pcs_pg_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 40,
  parameter int unsigned       CNT_WIDTH  = 32,
  parameter logic [LFSR_W-1:0] SEED       = '1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sonic_pcs_pg_if.slave        st,
  input  logic                 enable,
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [1:0]           pattern
);

  state_e                state;
  pattern_e              pat_q;
  pattern_e              sel;
  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     step_in;
  logic [LFSR_W-1:0]     step_next;
  logic [DATA_WIDTH-1:0] step_bits;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ready_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  transfer;
  logic                  accept;
  logic                  lfsr_zero;

  assign sel       = pattern_e'(st.in_data);
  assign transfer  = valid_q & st.out_ready;
  assign accept    = st.in_valid & ready_q;
  assign lfsr_zero = (lfsr & order_mask(pat_q)) == '0;
  // SEED and lockup recovery both generate straight from SEED in the same cycle
  assign step_in   = (state == ST_SEED || lfsr_zero) ? SEED : lfsr;

  sonic_pcs_pg_lfsr_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .state      (step_in),
    .pattern    (pat_q),
    .next_state (step_next),
    .bits       (step_bits)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pat_q   <= PAT_PRBS7;
      lfsr    <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (transfer) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          if (accept) begin
            pat_q   <= sel;
            state   <= ST_SEED;
            ready_q <= 1'b0;
          end
        end
        ST_SEED: begin
          lfsr    <= step_next;
          data_q  <= step_bits;
          valid_q <= enable;
          ready_q <= 1'b1;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          ready_q <= 1'b1;
          if (accept && sel != pat_q) begin
            pat_q   <= sel;
            state   <= ST_SEED;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
          end else begin
            valid_q <= enable;
            if (transfer) begin
              lfsr   <= step_next;
              data_q <= step_bits;
            end else if (lfsr_zero) begin
              lfsr <= SEED;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  logic err_flag;

  // A pulse arriving with the clearing transfer re-arms only if the flag was clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
    end else begin
      err_flag <= err_flag ? ~transfer : inject_err;
    end
  end

  assign st.out_data = {data_q[DATA_WIDTH-1:1], data_q[0] ^ err_flag};
`else
  assign st.out_data = data_q;
`endif

  assign st.out_valid = valid_q;
  assign st.in_ready  = ready_q;
  assign word_count   = count_q;
  assign pattern      = pat_q;

endmodule

// File: tb/tb_sonic_pcs_pg_prbs_generator.sv
// Directed bench for the PRBS generator: vector table plus multi-cycle sequences checked against a serial model.
`timescale 1ns/1ps
module tb_sonic_pcs_pg_prbs_generator;
  import sonic_pcs_pg_pkg::*;

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 32;
  localparam logic [DW-1:0] CLK_WORD = 40'hAAAAAAAAAA;
  localparam logic [DW-1:0] PRBS7_W0 = 40'h344F143040;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] word_count;
  logic [1:0]    pattern;
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
  logic          inject_err = 1'b0;
`endif

  sonic_pcs_pg_if #(.DATA_WIDTH(DW)) bus ();

  sonic_pcs_pg_prbs_generator #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .st         (bus),
    .enable     (enable),
`ifdef SONIC_PCS_PG_ERR_INJECT_EN
    .inject_err (inject_err),
`endif
    .word_count (word_count),
    .pattern    (pattern)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit bitq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial reference: b[n] = b[n-ORDER] ^ b[n-TAP], history starts all ones
  logic [30:0]   m_hist;
  pattern_e      m_pat;
  logic [DW-1:0] m_word;

  task automatic model_reset(input pattern_e p);
    m_pat  = p;
    m_hist = '1;
  endtask

  task automatic model_word(output logic [DW-1:0] w);
    logic b;
    for (int i = 0; i < DW; i++) begin
      case (m_pat)
        PAT_PRBS7:  b = m_hist[6]  ^ m_hist[5];
        PAT_PRBS15: b = m_hist[14] ^ m_hist[13];
        PAT_PRBS31: b = m_hist[30] ^ m_hist[27];
        default:    b = i[0];
      endcase
      w[i] = b;
      if (m_pat != PAT_CLK1010) m_hist = {m_hist[29:0], b};
    end
  endtask

  task automatic select(input pattern_e p);
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    @(negedge clk);
    check("sel_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_reset(p);
    model_word(m_word);
  endtask

  task automatic run_stream(input int n, input bit rnd, input int same_at, input string tag);
    logic [DW-1:0] held;
    bit stalled = 0;
    int got = 0;
    int cyc = 0;
    enable = 1'b1;
    while (got < n && cyc < 20 * n + 50) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid  = (got == same_at);
      bus.in_data   = m_pat;
      @(negedge clk);
      if (stalled && bus.out_valid) check({tag, "_stall_hold"}, 64'(bus.out_data), 64'(held));
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s_word%0d", tag, got), 64'(bus.out_data), 64'(m_word));
        for (int i = 0; i < DW; i++) bitq.push_back(bus.out_data[i]);
        got++;
        exp_cnt++;
        model_word(m_word);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (got < n) check({tag, "_timeout_words"}, 64'(got), 64'(n));
    @(negedge clk);
    check({tag, "_word_count"}, 64'(word_count), 64'(exp_cnt));
    @(posedge clk); #1;
  endtask

  typedef struct {
    int iv; int sel; int en; int rdy;
    int e_ir; int e_v; int chk; logic [DW-1:0] e_d; int e_cnt; int e_pat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int max_run, run, mism;
    vecs = '{
      '{1, 3, 1, 1,  1, 0, 0, 40'h0,    0, 0},
      '{0, 0, 1, 1,  0, 0, 0, 40'h0,    0, 3},
      '{0, 0, 1, 1,  1, 1, 1, CLK_WORD, 0, 3},
      '{0, 0, 1, 1,  1, 1, 1, CLK_WORD, 1, 3},
      '{0, 0, 1, 1,  1, 1, 1, CLK_WORD, 2, 3},
      '{0, 0, 0, 1,  1, 1, 1, CLK_WORD, 3, 3},
      '{0, 0, 1, 1,  1, 0, 1, CLK_WORD, 4, 3},
      '{0, 0, 1, 0,  1, 1, 1, CLK_WORD, 4, 3},
      '{0, 0, 1, 1,  1, 1, 1, CLK_WORD, 4, 3},
      '{1, 0, 1, 1,  1, 1, 1, CLK_WORD, 5, 3},
      '{0, 0, 1, 1,  0, 0, 0, 40'h0,    6, 0},
      '{0, 0, 1, 1,  1, 1, 1, PRBS7_W0, 6, 0},
      '{0, 0, 1, 0,  1, 1, 0, 40'h0,    7, 0}
    };

    bus.in_valid  = 1'b0;
    bus.in_data   = 2'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready",   64'(bus.in_ready),  64'(0));
    check("rst_out_valid",  64'(bus.out_valid), 64'(0));
    check("rst_out_data",   64'(bus.out_data),  64'(0));
    check("rst_word_count", 64'(word_count),    64'(0));
    check("rst_pattern",    64'(pattern),       64'(0));
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Clock pattern, enable gap, stall, and reselect coinciding with a transfer
    foreach (vecs[i]) begin
      bus.in_valid  = 1'(vecs[i].iv);
      bus.in_data   = 2'(vecs[i].sel);
      enable        = 1'(vecs[i].en);
      bus.out_ready = 1'(vecs[i].rdy);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i),   64'(bus.in_ready),  64'(vecs[i].e_ir));
      check($sformatf("v%0d_out_valid", i),  64'(bus.out_valid), 64'(vecs[i].e_v));
      check($sformatf("v%0d_word_count", i), 64'(word_count),    64'(vecs[i].e_cnt));
      check($sformatf("v%0d_pattern", i),    64'(pattern),       64'(vecs[i].e_pat));
      if (vecs[i].chk != 0) check($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(vecs[i].e_d));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    // PRBS7 over a full period from a fresh reset
    reset_n = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
    bitq.delete();
    select(PAT_PRBS7);
    run_stream(127, 1'b0, -1, "prbs7");
    mism = 0;
    for (int i = 0; i + 127 < bitq.size(); i++) if (bitq[i] != bitq[i + 127]) mism++;
    check("prbs7_period127", 64'(mism), 64'(0));
    max_run = 0;
    run = 0;
    foreach (bitq[i]) begin
      run = bitq[i] ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    check("prbs7_max_zero_run", 64'(max_run), 64'(6));

    // PRBS31 under random backpressure, with a same-pattern select mid-stream
    select(PAT_PRBS31);
    run_stream(60, 1'b1, 20, "prbs31");
    check("prbs31_pattern", 64'(pattern), 64'(2));

    // PRBS15, then select PRBS7 in the same cycle as a transfer
    select(PAT_PRBS15);
    run_stream(5, 1'b0, -1, "prbs15");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 2'd0;
    @(negedge clk);
    check("simul_pre_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_cnt++;
    @(negedge clk);
    check("simul_seed_valid", 64'(bus.out_valid), 64'(0));
    check("simul_seed_count", 64'(word_count),    64'(exp_cnt));
    check("simul_pattern",    64'(pattern),       64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("simul_run_valid",  64'(bus.out_valid), 64'(1));
    check("simul_first_word", 64'(bus.out_data),  64'(PRBS7_W0));
    @(posedge clk); #1;
    exp_cnt++;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("simul_post_count", 64'(word_count), 64'(exp_cnt));
    @(posedge clk); #1;

    // Asynchronous one-cycle reset in the middle of a running stream
    bus.out_ready = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("midrst_out_valid",  64'(bus.out_valid), 64'(0));
    check("midrst_in_ready",   64'(bus.in_ready),  64'(0));
    check("midrst_out_data",   64'(bus.out_data),  64'(0));
    check("midrst_word_count", 64'(word_count),    64'(0));
    check("midrst_pattern",    64'(pattern),       64'(0));
    #9 reset_n = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 0;
    select(PAT_PRBS7);
    run_stream(3, 1'b0, -1, "reseed");

`ifdef SONIC_PCS_PG_ERR_INJECT_EN
    begin
      logic [DW-1:0] diff;
      int ndiff = 0;
      int got = 0;
      int cyc = 0;
      inject_err = 1'b1; @(posedge clk); #1;
      inject_err = 1'b0; @(posedge clk); #1;
      inject_err = 1'b1; @(posedge clk); #1;
      inject_err = 1'b0;
      while (got < 6 && cyc < 60) begin
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (bus.out_valid) begin
          diff = bus.out_data ^ m_word;
          if (diff != '0) ndiff++;
          check($sformatf("inj_word%0d_upper_bits", got), 64'(diff & ~DW'(1)), 64'(0));
          got++;
          exp_cnt++;
          model_word(m_word);
        end
        @(posedge clk); #1;
        cyc++;
      end
      bus.out_ready = 1'b0;
      check("inj_words_seen", 64'(got), 64'(6));
      check("inj_corrupted_words", 64'(ndiff), 64'(1));
      @(negedge clk);
      check("inj_word_count", 64'(word_count), 64'(exp_cnt));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_pcs_pg_prbs_generator.md
Name: sonic_pcs_pg_prbs_generator

Overview:
- Sits directly downstream of the PCS pattern-generator "before" timing adapter.
- Consumes the adapter's 2-bit pattern-select Avalon-ST stream.
- Produces a backpressurable Avalon-ST stream of parallel PRBS or clock-pattern words toward the PCS TX datapath.
- Keeps a count of words delivered, for the pattern-analyzer side to compare against.

Parameters:
- DATA_WIDTH, 40: output word width. Must be even and ≥ 32.
- CNT_WIDTH, 32: width of the delivered-word counter.
- SEED, all-ones: LFSR seed. Only the low bits needed by the active polynomial are used; a nonzero seed is required.

Ports:
- clk  in  1  single clock for the whole block
- reset_n  in  1  asynchronous, active-low reset (assert asynchronously, deassert synchronously to clk)
- in_data  in  2  pattern select: 0=PRBS7, 1=PRBS15, 2=PRBS31, 3=clock pattern 1010
- in_valid  in  1  select valid
- in_ready  out  1  select accepted when in_valid & in_ready
- enable  in  1  generator run enable
- out_data  out  DATA_WIDTH  pattern word; bit 0 is transmitted first
- out_valid  out  1  word valid
- out_ready  in  1  downstream ready
- word_count  out  CNT_WIDTH  number of words accepted downstream
- pattern  out  2  currently active select

Behaviour:
- Reset values: out_data=0, out_valid=0, in_ready=0 while reset_n is low, word_count=0, pattern=0, state=IDLE, LFSR=SEED.
- States:
  - IDLE: in_ready=1, out_valid=0. An accepted select loads pattern and moves to SEED.
  - SEED: one cycle. in_ready=0, out_valid=0. LFSR is loaded with SEED; out_data receives the first word generated from SEED; LFSR advances DATA_WIDTH steps. Next state is RUN.
  - RUN: in_ready=1. out_valid=enable (registered, so it follows enable one cycle later).
- Handshake:
  - A word transfers when out_valid & out_ready.
  - On transfer: out_data is replaced by the next word, LFSR advances DATA_WIDTH steps, and word_count increments (wrapping at 2^CNT_WIDTH).
  - While out_valid=1 and out_ready=0, out_data and the LFSR hold.
- Latency: a select accepted in cycle N gives the SEED state in N+1 and out_valid=1 in N+2 (if enable=1).
- Select handling in RUN:
  - A select different from pattern goes to SEED.
  - The word being presented is dropped without a transfer; word_count is not reset.
  - A select equal to pattern is accepted and ignored, with no reseed.
- Polynomials: PRBS7 x^7+x^6+1, PRBS15 x^15+x^14+1, PRBS31 x^31+x^28+1. Fibonacci form: output bit = new feedback bit, then shift left.
- Clock pattern: out_data = DATA_WIDTH/2 repetitions of 2'b10, i.e. bit0=0, bit1=1. The LFSR is idle.
- enable low in RUN: out_valid drops the next cycle and the LFSR and out_data hold. When enable returns, generation resumes with the held word; nothing is skipped or duplicated.
- Simultaneous events:
  - Transfer and a new select in the same cycle: the transfer counts, then SEED.
  - In SEED, in_valid is ignored (in_ready=0).
- Reset mid-operation: everything returns to reset values immediately; the next select reseeds.
- LFSR lockup: an all-zero state is unreachable from a nonzero SEED. If it is ever detected, the LFSR is reloaded with SEED.

Optional Feature:
- Macro: SONIC_PCS_PG_ERR_INJECT_EN.
- Defined:
  - Adds input port inject_err (1 bit).
  - A pulse sets a sticky flag. The next transferred word has bit 0 inverted in out_data only (LFSR unaffected), and the flag clears on that transfer.
  - Pulses while the flag is already set are merged.
- Undefined: no port, no inversion logic, no extra flops.

Decomposition:
- Package sonic_pcs_pg_pkg:
  - pattern-select typedef/enum (PRBS7, PRBS15, PRBS31, CLK1010)
  - tap constants and polynomial orders
  - FSM state typedef (IDLE, SEED, RUN)
- Sub-module sonic_pcs_pg_lfsr_step:
  - combinational DATA_WIDTH-step parallel LFSR
  - inputs: 31-bit state and pattern; outputs: next state and DATA_WIDTH output bits
  - separately unit-testable against a serial model

Test Plan:
- Reset, then select 3, out_ready=1, enable=1 → out_valid rises 2 cycles after acceptance; out_data=40'hAAAAAAAAAA every cycle; word_count increments by 1 per cycle.
- Select 0 (PRBS7), out_ready=1 for 127 words → bitstream matches the serial x^7+x^6+1 model from an all-ones seed; the sequence repeats with period 127 bits; there are never 7 consecutive zeros.
- PRBS31 with out_ready toggling randomly at 50% → out_data stable while stalled; the concatenated transferred words equal the serial model with no gaps or repeats; word_count equals the number of handshakes.
- In RUN with PRBS15, send select 0 in the same cycle as a transfer → that transfer is counted; out_valid low for 1 cycle; the first new word equals the PRBS7 seed word; pattern=0.
- Assert reset_n low mid-stream for 1 cycle (asynchronously) → outputs return to reset values within that cycle; in_ready=0 while in reset; word_count=0.
- With SONIC_PCS_PG_ERR_INJECT_EN defined, pulse inject_err twice while stalled → exactly one transferred word differs from the model, only in bit 0; subsequent words match the model.
